// File: rtl/icg_enable_ctrl_if.sv
// Signal bundle between a clock-gated domain, its wake initiator and the ICG enable controller.
// REQ/ACK is four-phase: REQ rises, ACK rises, REQ falls, ACK falls; REQ must hold until ACK rises.
interface icg_enable_ctrl_if;
  logic BUSY;
  logic REQ;
  logic SCAN_EN;
  logic E;
  logic TE;
  logic ACK;
  logic GATED;

  modport master (
    output BUSY, REQ, SCAN_EN,
    input  E, TE, ACK, GATED
  );

  modport slave (
    input  BUSY, REQ, SCAN_EN,
    output E, TE, ACK, GATED
  );
endinterface

// File: rtl/icg_enable_ctrl.sv
// Idle-detect controller for an ICG cell: gates the downstream clock after IDLE_CYCLES idle
// edges and re-enables it on BUSY/REQ, acknowledging REQ only once WAKE_CYCLES have elapsed.
module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                CLK,
  input  logic                RST,
  icg_enable_ctrl_if.slave    bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_GATED = 2'd1,
    S_WAKE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic             e_q, e_d;
  logic             te_q;
  logic             ack_q, ack_d;
  logic             gated_q, gated_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic             idle;

  // ACK in the idle term keeps the domain clocked until the handshake has fully returned to zero.
  assign idle = !bus.BUSY && !bus.REQ && !ack_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RUN;
      e_q        <= 1'b1;
      te_q       <= 1'b0;
      ack_q      <= 1'b0;
      gated_q    <= 1'b0;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      te_q       <= bus.SCAN_EN;
      ack_q      <= ack_d;
      gated_q    <= gated_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    ack_d      = ack_q;
    gated_d    = gated_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    if (bus.SCAN_EN) begin
      state_d    = S_RUN;
      e_d        = 1'b1;
      gated_d    = 1'b0;
      ack_d      = bus.REQ;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          ack_d = bus.REQ;
          if (!idle) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d    = S_GATED;
            e_d        = 1'b0;
            gated_d    = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_ONE;
          end
        end
        S_GATED: begin
          if (bus.BUSY || bus.REQ) begin
            state_d    = S_WAKE;
            e_d        = 1'b1;
            gated_d    = 1'b0;
            wake_cnt_d = '0;
          end
        end
        S_WAKE: begin
          // Runs to completion regardless of BUSY/REQ so the gated domain always settles.
          ack_d = 1'b0;
          if (wake_cnt_q == WAKE_LAST) begin
            state_d    = S_RUN;
            wake_cnt_d = '0;
          end else begin
            wake_cnt_d = wake_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_RUN;
          e_d     = 1'b1;
          gated_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.E     = e_q;
  assign bus.TE    = te_q;
  assign bus.ACK   = ack_q;
  assign bus.GATED = gated_q;
  assign dbg_state = state_q;
endmodule
